mips_cpu_hilo: RTL and testbench
================================

// Module: mips_cpu_hilo
// PURPOSE
//  HI/LO special-register unit sitting directly downstream of the 32x32 multiplier.
//  Tracks in-flight MULT/MULTU, captures the 64-bit product into HI/LO after a fixed
//  latency, and services DIV results, MTHI/MTLO writes and MFHI/MFLO reads.
//  Raises stall to the pipeline when an MFHI/MFLO would read a stale value.
// PARAMETERS
//  MULT_LATENCY  1   cycles from mult_start to mult_r valid (>=1; 1 = single-register multiplier)
//  CNT_W         4   width of latency counter; must hold MULT_LATENCY
// PORTS
//  clk        in   1   clock, all state on posedge
//  reset      in   1   synchronous, active-low reset (0 = reset)
//  mult_start in   1   MULT/MULTU operands presented to multiplier this cycle
//  mult_r     in   64  multiplier product; valid MULT_LATENCY cycles after mult_start
//  div_valid  in   1   divider result valid this cycle
//  div_q      in   32  quotient  -> LO
//  div_rem    in   32  remainder -> HI
//  mthi_en    in   1   MTHI write
//  mtlo_en    in   1   MTLO write
//  wdata      in   32  MTHI/MTLO data
//  rd_hi_en   in   1   MFHI request
//  rd_lo_en   in   1   MFLO request
//  hi         out  32  current HI register
//  lo         out  32  current LO register
//  rdata      out  32  MFHI/MFLO read data
//  busy       out  1   multiply in flight (cnt != 0)
//  stall      out  1   read request cannot be served this cycle
// BEHAVIOUR
//  - Reset (reset==0 at posedge): hi=0, lo=0, cnt=0; hence busy=0, stall=0, rdata=0.
//    Reset mid-multiply discards the pending product.
//  - Counter: mult_start loads cnt=MULT_LATENCY; else cnt!=0 decrements by 1.
//  - Capture: in a cycle with cnt==1 (not cancelled): {hi,lo} <= mult_r at posedge;
//    new value visible the following cycle. L=1: start T, capture end of T+1, read T+2.
//  - Back-to-back mult_start while busy: counter reloads; earlier product never captured.
//  - div_valid: hi<=div_rem, lo<=div_q; cancels any pending multiply (cnt<=0).
//  - mthi_en/mtlo_en: write the addressed half only, other half held; also cancel pending
//    multiply, including in a cnt==1 cycle (no product half is written).
//  - mult_start, div_valid, mthi_en, mtlo_en mutually exclusive (single-issue); if violated,
//    priority mult_start > div_valid > mthi_en > mtlo_en; lower ones ignored.
//  - rdata combinational: rd_hi_en ? hi : rd_lo_en ? lo : 0 (both set -> hi).
//  - stall = (rd_hi_en | rd_lo_en) & busy; requester holds request until stall=0.
//  - Product is stored as-is (64 bits, no truncation); signedness handled upstream.
// CONFIGURATION
//  MIPS_CPU_HILO_BYPASS_EN defined: in a cnt==1 cycle with no cancel, rdata forwards
//   mult_r[63:32] (hi) / mult_r[31:0] (lo) and stall=0 for that cycle; stall only for cnt>1.
//  Not defined: no forwarding; reads stall through the capture cycle (stall while cnt!=0).
// TESTING
//  1. reset=0 for 2 cycles with random inputs -> hi=lo=rdata=0, busy=stall=0.
//  2. L=1: mult_start, then mult_r=64'h0000_0001_FFFF_FFFE -> busy 1 cycle;
//     hi=32'h1, lo=32'hFFFF_FFFE two cycles after start.
//  3. L=3: mult_start + rd_lo_en held -> stall 3 cycles (2 with BYPASS_EN),
//     then rdata=product[31:0].
//  4. mult_start, next cycle mthi_en wdata=32'hDEAD_BEEF -> busy drops, hi=DEADBEEF,
//     lo unchanged, product never written.
//  5. div_valid div_q=7, div_rem=3 -> lo=7, hi=3; rd_hi_en -> rdata=3, stall=0.
//  6. mult_start at T and T+1 (L=2) with distinct products -> only second product lands in HI/LO.

Source files
------------

// File: rtl/mips_cpu_hilo.sv
// HI/LO special-register unit behind the 32x32 multiplier: tracks in-flight products,
// applies DIV/MTHI/MTLO writes and serves MFHI/MFLO. Optional MIPS_CPU_HILO_BYPASS_EN forwards the capture-cycle product.
module mips_cpu_hilo #(
    parameter int unsigned MULT_LATENCY = 1,
    parameter int unsigned CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mult_start,
    input  logic [63:0] mult_r,
    input  logic        div_valid,
    input  logic [31:0] div_q,
    input  logic [31:0] div_rem,
    input  logic        mthi_en,
    input  logic        mtlo_en,
    input  logic [31:0] wdata,
    input  logic        rd_hi_en,
    input  logic        rd_lo_en,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        stall
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(MULT_LATENCY);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        OP_NONE,
        OP_MULT,
        OP_DIV,
        OP_MTHI,
        OP_MTLO
    } op_e;

    op_e              op;
    logic             capture;
    logic             rd_req;
    logic [31:0]      hi_src;
    logic [31:0]      lo_src;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    // Single-issue sources; a violated exclusivity resolves to the highest-priority op.
    always_comb begin
        op = OP_NONE;
        if (mult_start)     op = OP_MULT;
        else if (div_valid) op = OP_DIV;
        else if (mthi_en)   op = OP_MTHI;
        else if (mtlo_en)   op = OP_MTLO;
    end

    // Any issued op, including a new multiply, cancels the product due this cycle.
    assign capture = (cnt_q == ONE) && (op == OP_NONE);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (cnt_q != '0) cnt_d = cnt_q - ONE;
        if (capture) {hi_d, lo_d} = mult_r;
        case (op)
            OP_MULT: cnt_d = LAT;
            OP_DIV: begin
                hi_d  = div_rem;
                lo_d  = div_q;
                cnt_d = '0;
            end
            OP_MTHI: begin
                hi_d  = wdata;
                cnt_d = '0;
            end
            OP_MTLO: begin
                lo_d  = wdata;
                cnt_d = '0;
            end
            default: ;
        endcase
    end

    // NOTE: reset is synchronous active-low, so it is tested inside the clocked block only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments to avoid ordering races.
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign hi     = hi_q;
    assign lo     = lo_q;
    assign busy   = (cnt_q != '0);
    assign rd_req = rd_hi_en | rd_lo_en;

`ifdef MIPS_CPU_HILO_BYPASS_EN
    assign hi_src = capture ? mult_r[63:32] : hi_q;
    assign lo_src = capture ? mult_r[31:0]  : lo_q;
    assign stall  = rd_req & busy & ~capture;
`else
    assign hi_src = hi_q;
    assign lo_src = lo_q;
    assign stall  = rd_req & busy;
`endif

    assign rdata = rd_hi_en ? hi_src : (rd_lo_en ? lo_src : 32'h0);

endmodule

// File: tb/tb_mips_cpu_hilo.sv
// Scoreboard bench for mips_cpu_hilo: three instances (latency 1, 2, 3) share stimulus;
// read expectations are queued at issue and popped by a monitor when a read is accepted.
module tb_mips_cpu_hilo;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_start;
    logic [63:0] mult_r;
    logic        div_valid;
    logic [31:0] div_q;
    logic [31:0] div_rem;
    logic        mthi_en;
    logic        mtlo_en;
    logic [31:0] wdata;
    logic        rd_hi_en;
    logic        rd_lo_en;

    logic [31:0] hi_w    [1:3];
    logic [31:0] lo_w    [1:3];
    logic [31:0] rdata_w [1:3];
    logic        busy_w  [1:3];
    logic        stall_w [1:3];

    int          sel = 1;
    logic [31:0] hi_s, lo_s, rdata_s;
    logic        busy_s, stall_s;

    int          n_cmp = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    logic [31:0] exp_q [$];

`ifdef MIPS_CPU_HILO_BYPASS_EN
    localparam int EXP_ST3 = 2;
`else
    localparam int EXP_ST3 = 3;
`endif

    always #5 clk = ~clk;

    mips_cpu_hilo #(.MULT_LATENCY(1), .CNT_W(4)) u_l1 (
        .clk(clk), .reset(reset), .mult_start(mult_start), .mult_r(mult_r),
        .div_valid(div_valid), .div_q(div_q), .div_rem(div_rem),
        .mthi_en(mthi_en), .mtlo_en(mtlo_en), .wdata(wdata),
        .rd_hi_en(rd_hi_en), .rd_lo_en(rd_lo_en),
        .hi(hi_w[1]), .lo(lo_w[1]), .rdata(rdata_w[1]), .busy(busy_w[1]), .stall(stall_w[1])
    );
    mips_cpu_hilo #(.MULT_LATENCY(2), .CNT_W(4)) u_l2 (
        .clk(clk), .reset(reset), .mult_start(mult_start), .mult_r(mult_r),
        .div_valid(div_valid), .div_q(div_q), .div_rem(div_rem),
        .mthi_en(mthi_en), .mtlo_en(mtlo_en), .wdata(wdata),
        .rd_hi_en(rd_hi_en), .rd_lo_en(rd_lo_en),
        .hi(hi_w[2]), .lo(lo_w[2]), .rdata(rdata_w[2]), .busy(busy_w[2]), .stall(stall_w[2])
    );
    mips_cpu_hilo #(.MULT_LATENCY(3), .CNT_W(4)) u_l3 (
        .clk(clk), .reset(reset), .mult_start(mult_start), .mult_r(mult_r),
        .div_valid(div_valid), .div_q(div_q), .div_rem(div_rem),
        .mthi_en(mthi_en), .mtlo_en(mtlo_en), .wdata(wdata),
        .rd_hi_en(rd_hi_en), .rd_lo_en(rd_lo_en),
        .hi(hi_w[3]), .lo(lo_w[3]), .rdata(rdata_w[3]), .busy(busy_w[3]), .stall(stall_w[3])
    );

    assign hi_s    = hi_w[sel];
    assign lo_s    = lo_w[sel];
    assign rdata_s = rdata_w[sel];
    assign busy_s  = busy_w[sel];
    assign stall_s = stall_w[sel];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: an accepted read (request high, no stall) consumes one queued expectation.
    always @(negedge clk) begin
        if (mon_en && (rd_hi_en || rd_lo_en) && !stall_s) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rdata_unexpected: read accepted with rdata %h, nothing queued", rdata_s);
            end else begin
                check("rdata", 64'(rdata_s), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        mult_start = 1'b0;
        div_valid  = 1'b0;
        mthi_en    = 1'b0;
        mtlo_en    = 1'b0;
        repeat (n) tick();
    endtask

    // Issue a read, hold it until accepted (bounded), report stall cycles seen.
    task automatic do_read(input bit hi_sel, input logic [31:0] exp, output int stalls);
        exp_q.push_back(exp);
        if (hi_sel) rd_hi_en = 1'b1;
        else        rd_lo_en = 1'b1;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!stall_s) break;
            stalls++;
            if (stalls > 20) begin
                check("read_timeout", 64'(stalls), 64'(0));
                break;
            end
        end
        tick();
        rd_hi_en = 1'b0;
        rd_lo_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st;
        reset = 1'b0; mult_start = 1'b0; mult_r = '0; div_valid = 1'b0; div_q = '0;
        div_rem = '0; mthi_en = 1'b0; mtlo_en = 1'b0; wdata = '0; rd_hi_en = 1'b0; rd_lo_en = 1'b0;

        // 1: reset with random inputs
        repeat (2) begin
            mult_start = 1'($urandom); mult_r = {$urandom, $urandom}; div_valid = 1'($urandom);
            div_q = $urandom; div_rem = $urandom; mthi_en = 1'($urandom); mtlo_en = 1'($urandom);
            wdata = $urandom; rd_hi_en = 1'($urandom); rd_lo_en = 1'($urandom);
            tick();
        end
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            sel = k;
            #1;
            check("rst_hi", 64'(hi_s), 64'h0);
            check("rst_lo", 64'(lo_s), 64'h0);
            check("rst_rdata", 64'(rdata_s), 64'h0);
            check("rst_busy", 64'(busy_s), 64'h0);
            check("rst_stall", 64'(stall_s), 64'h0);
        end
        tick();
        reset = 1'b1; rd_hi_en = 1'b0; rd_lo_en = 1'b0; mult_r = '0;
        idle(2);
        mon_en = 1'b1;

        // 2: L=1 capture timing
        sel = 1;
        mult_start = 1'b1; mult_r = 64'h0000_0001_FFFF_FFFE;
        @(negedge clk); check("t2_busy_T", 64'(busy_s), 64'h0);
        tick(); mult_start = 1'b0;
        @(negedge clk); check("t2_busy_T1", 64'(busy_s), 64'h1);
        check("t2_hi_T1", 64'(hi_s), 64'h0);
        tick();
        @(negedge clk); check("t2_busy_T2", 64'(busy_s), 64'h0);
        check("t2_hi_T2", 64'(hi_s), 64'h1);
        check("t2_lo_T2", 64'(lo_s), 64'hFFFF_FFFE);
        tick();
        do_read(1'b1, 32'h1, st);
        do_read(1'b0, 32'hFFFF_FFFE, st);
        idle(4);

        // 3: L=3 read stalls until product available
        sel = 3;
        mult_start = 1'b1; mult_r = 64'h1234_5678_9ABC_DEF0;
        tick(); mult_start = 1'b0;
        do_read(1'b0, 32'h9ABC_DEF0, st);
        check("t3_stall_cycles", 64'(st), 64'(EXP_ST3));
        idle(4);
        do_read(1'b1, 32'h1234_5678, st);

        // 4: MTHI cancels pending multiply (L=1 instance sees it in its cnt==1 cycle)
        sel = 2;
        mult_start = 1'b1; mult_r = 64'hAAAA_AAAA_5555_5555;
        tick(); mult_start = 1'b0; mthi_en = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk); check("t4_busy_T1", 64'(busy_s), 64'h1);
        tick(); mthi_en = 1'b0;
        @(negedge clk); check("t4_busy_T2", 64'(busy_s), 64'h0);
        idle(4);
        for (int k = 1; k <= 3; k++) begin
            sel = k;
            #1;
            check("t4_hi", 64'(hi_s), 64'hDEAD_BEEF);
            check("t4_lo", 64'(lo_s), 64'h9ABC_DEF0);
        end
        sel = 2;
        do_read(1'b1, 32'hDEAD_BEEF, st);

        // 5: divider result
        div_valid = 1'b1; div_q = 32'd7; div_rem = 32'd3;
        tick(); div_valid = 1'b0;
        do_read(1'b1, 32'd3, st);
        check("t5_stall_cycles", 64'(st), 64'h0);
        do_read(1'b0, 32'd7, st);

        // 6: back-to-back starts; product bus shows A at T+2, B at T+3, junk at T+4
        mult_start = 1'b1; mult_r = 64'h0;
        tick();
        tick(); mult_start = 1'b0; mult_r = 64'h1111_1111_2222_2222;
        tick(); mult_r = 64'h3333_3333_4444_4444;
        tick(); mult_r = 64'h5555_5555_6666_6666;
        tick(); mult_r = 64'h0;
        idle(3);
        sel = 2; #1;
        check("t6_l2_hi", 64'(hi_s), 64'h3333_3333);
        check("t6_l2_lo", 64'(lo_s), 64'h4444_4444);
        sel = 1; #1;
        check("t6_l1_hi", 64'(hi_s), 64'h1111_1111);
        sel = 3; #1;
        check("t6_l3_lo", 64'(lo_s), 64'h6666_6666);
        sel = 2;
        do_read(1'b0, 32'h4444_4444, st);

        // 7: reset mid-multiply discards the product
        sel = 3;
        mult_start = 1'b1; mult_r = 64'h7777_7777_8888_8888;
        tick(); mult_start = 1'b0; reset = 1'b0;
        tick(); reset = 1'b1;
        @(negedge clk); check("t7_busy", 64'(busy_s), 64'h0);
        idle(4);
        check("t7_hi", 64'(hi_s), 64'h0);
        check("t7_lo", 64'(lo_s), 64'h0);

        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
